// File: rtl/approx_adder_rr_arbiter.sv
// Round-robin front end sharing one external combinational approximate adder
// between two valid/ready requesters; operands and mask are registered toward the adder.
module approx_adder_rr_arbiter #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned MASK_W   = 3,
   parameter int unsigned MASK_MAX = 7,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [WIDTH-1:0]  req0_in1,
   input  logic [WIDTH-1:0]  req0_in2,
   input  logic [MASK_W-1:0] req0_mask,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [WIDTH-1:0]  rsp0_sum,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [WIDTH-1:0]  req1_in1,
   input  logic [WIDTH-1:0]  req1_in2,
   input  logic [MASK_W-1:0] req1_mask,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [WIDTH-1:0]  rsp1_sum,
   output logic [WIDTH-1:0]  add_in1,
   output logic [WIDTH-1:0]  add_in2,
   output logic [MASK_W-1:0] add_mask,
   input  logic [WIDTH-1:0]  add_out,
   output logic [CNT_W-1:0]  gnt_cnt0,
   output logic [CNT_W-1:0]  gnt_cnt1,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state;
   logic              last_grant;
   logic              gnt_id;
   logic              win0;
   logic              win1;
   logic [MASK_W-1:0] mask_sel;
   logic [MASK_W-1:0] mask_clamped;

   // Requester 0 wins alone or when both are valid and 1 was served last.
   always_comb begin
      win0 = 1'b0;
      win1 = 1'b0;
      if (state == IDLE) begin
         if (req0_valid && (!req1_valid || last_grant))
            win0 = 1'b1;
         else if (req1_valid)
            win1 = 1'b1;
      end
      mask_sel     = win1 ? req1_mask : req0_mask;
      mask_clamped = (32'(mask_sel) > MASK_MAX) ? MASK_W'(MASK_MAX) : mask_sel;
   end

   assign req0_ready = win0;
   assign req1_ready = win1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         gnt_id     <= 1'b0;
         add_in1    <= '0;
         add_in2    <= '0;
         add_mask   <= '0;
         rsp0_sum   <= '0;
         rsp1_sum   <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         gnt_cnt0   <= '0;
         gnt_cnt1   <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win0 || win1) begin
                  add_in1    <= win1 ? req1_in1 : req0_in1;
                  add_in2    <= win1 ? req1_in2 : req0_in2;
                  add_mask   <= mask_clamped;
                  gnt_id     <= win1;
                  last_grant <= win1;
                  if (win1)
                     gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
                  else
                     gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
                  state      <= EXEC;
                  busy       <= 1'b1;
               end
            end
            EXEC: begin
               if (gnt_id) begin
                  rsp1_sum   <= add_out;
                  rsp1_valid <= 1'b1;
               end else begin
                  rsp0_sum   <= add_out;
                  rsp0_valid <= 1'b1;
               end
               state <= RESP;
            end
            RESP: begin
               if (gnt_id ? rsp1_ready : rsp0_ready) begin
                  rsp0_valid <= 1'b0;
                  rsp1_valid <= 1'b0;
                  state      <= IDLE;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
